rmii_rx_frame: RTL and testbench

//  Hardware RMII receive path for the Ethernet PHY port. It replaces software

---
 rtl/rmii_rx_frame_if.sv | 20 ++
 rtl/rmii_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_rmii_rx_frame.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rmii_rx_frame_if.sv
// OPB register-bus and RMII pin bundle for the RMII receive framer.
interface rmii_rx_frame_if;
  logic [31:0] opb_addr;
  logic        phy_re;
  logic [31:0] opb_do;
  logic        phy_rmii_rx_data1;
  logic        phy_rmii_rx_data0;
  logic        phy_rmii_rx_dv;
  logic        rx_irq;

  modport master (
    output opb_addr, phy_re, phy_rmii_rx_data1, phy_rmii_rx_data0, phy_rmii_rx_dv,
    input  opb_do, rx_irq
  );

  modport slave (
    input  opb_addr, phy_re, phy_rmii_rx_data1, phy_rmii_rx_data0, phy_rmii_rx_dv,
    output opb_do, rx_irq
  );
endinterface

// File: rtl/rmii_rx_frame.sv
// RMII receive framer: preamble/SFD hunt, dibit-to-byte assembly and a tagged
// byte FIFO drained over the OPB register bus.
module rmii_rx_frame #(
  parameter int FIFO_AW = 6,
  parameter int PRE_MIN = 8
) (
  input logic            opb_clk,
  input logic            opb_rst,
  rmii_rx_frame_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = $clog2(PRE_MIN + 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      d_p0;
  logic            dv_p0;
  logic            armed;
  logic [PW-1:0]   pre_cnt;
  logic [1:0]      dib_cnt;
  logic [5:0]      sh;
  logic [7:0]      held;
  logic            held_vld;
  logic            push_req, push, pop, room, ovf_set, ovf;
  logic [9:0]      push_data, rd_ent;
  logic [9:0]      mem [DEPTH];
  logic [FIFO_AW:0] wp, rp, count;
  logic            full, empty, stat_rd;
  logic [8:0]      frames_pending;
  logic [31:0]     stat_word;

  function automatic logic [PW-1:0] pre_inc(input logic [PW-1:0] v);
    return (v >= PW'(PRE_MIN)) ? v : v + PW'(1);
  endfunction

  // Input stage p0: pins registered once
  always_ff @(posedge opb_clk) d_p0 <= {bus.phy_rmii_rx_data1, bus.phy_rmii_rx_data0};

  // armed stays low after reset until DV is seen low, so a frame in flight at release is ignored
  always_ff @(posedge opb_clk or posedge opb_rst) begin
    if (opb_rst) begin
      dv_p0 <= 1'b0;
      armed <= 1'b0;
    end else begin
      dv_p0 <= bus.phy_rmii_rx_dv;
      if (!bus.phy_rmii_rx_dv) armed <= 1'b1;
    end
  end

  assign count   = wp - rp;
  assign full    = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ent  = mem[rp[FIFO_AW-1:0]];
  assign pop     = bus.phy_re && !bus.opb_addr[2] && !empty;
  assign stat_rd = bus.phy_re && bus.opb_addr[2];
  assign room    = !full || pop;
  assign push    = push_req && room;
  assign ovf_set = push_req && !room;

  always_ff @(posedge opb_clk or posedge opb_rst) begin
    if (opb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_data = '0;
    case (state)
      IDLE: if (dv_p0) state_nxt = (armed && d_p0 == 2'b01) ? PRE : DROP;
      PRE: begin
        if (!dv_p0)                state_nxt = IDLE;
        else if (d_p0 == 2'b11)    state_nxt = (pre_cnt >= PW'(PRE_MIN)) ? DATA : DROP;
        else if (d_p0 != 2'b01)    state_nxt = DROP;
      end
      DATA: begin
        if (!dv_p0) begin
          state_nxt = IDLE;
          if (held_vld) begin
            push_req  = 1'b1;
            push_data = {dib_cnt != 2'd0, 1'b1, held};
          end
        end else if (dib_cnt == 2'd3 && held_vld) begin
          push_req  = 1'b1;
          push_data = {2'b00, held};
        end
      end
      DROP: if (!dv_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // an overflow abandons the frame; if DV already dropped there is nothing left to skip
    if (ovf_set) state_nxt = dv_p0 ? DROP : IDLE;
  end

  always_ff @(posedge opb_clk or posedge opb_rst) begin
    if (opb_rst) begin
      pre_cnt  <= '0;
      dib_cnt  <= '0;
      held_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pre_cnt  <= (d_p0 == 2'b01) ? PW'(1) : '0;
          dib_cnt  <= '0;
          held_vld <= 1'b0;
        end
        PRE: begin
          if (d_p0 == 2'b01) pre_cnt <= pre_inc(pre_cnt);
          dib_cnt <= '0;
        end
        DATA: begin
          if (dv_p0) begin
            dib_cnt <= dib_cnt + 2'd1;
            if (dib_cnt == 2'd3) held_vld <= 1'b1;
          end else begin
            dib_cnt  <= '0;
            held_vld <= 1'b0;
          end
        end
        default: begin
          dib_cnt  <= '0;
          held_vld <= 1'b0;
        end
      endcase
    end
  end

  // Assembly stage p1: LSB dibit first, the fourth dibit completes the byte
  always_ff @(posedge opb_clk) begin
    if (state == DATA && dv_p0) begin
      sh <= {d_p0, sh[5:2]};
      if (dib_cnt == 2'd3) held <= {d_p0, sh};
    end
  end

  always_ff @(posedge opb_clk) if (push) mem[wp[FIFO_AW-1:0]] <= push_data;

  assign stat_word = {12'b0, ovf, full, empty, frames_pending, 8'(count)};

  // Register stage p2: FIFO pointers, frame accounting and OPB read data
  always_ff @(posedge opb_clk or posedge opb_rst) begin
    if (opb_rst) begin
      wp             <= '0;
      rp             <= '0;
      frames_pending <= '0;
      ovf            <= 1'b0;
      bus.opb_do     <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push && push_data[8], pop && rd_ent[8]})
        2'b10:   frames_pending <= frames_pending + 9'd1;
        2'b01:   frames_pending <= frames_pending - 9'd1;
        default: ;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;
      if (bus.phy_re) begin
        if (bus.opb_addr[2]) bus.opb_do <= stat_word;
        else if (!empty)     bus.opb_do <= {1'b1, 21'b0, rd_ent};
        else                 bus.opb_do <= '0;
      end
    end
  end

  assign bus.rx_irq = (frames_pending != 9'd0);
endmodule

// File: tb/tb_rmii_rx_frame.sv
// Randomized and directed bench for rmii_rx_frame against a frame-level model.
module tb_rmii_rx_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   rd_mode = 0;
  logic [7:0]  fb [0:127];
  logic [31:0] got;

  rmii_rx_frame_if bus();

  rmii_rx_frame #(.FIFO_AW(6), .PRE_MIN(8)) dut (
    .opb_clk(clk),
    .opb_rst(rst),
    .bus(bus.slave)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, g, e, $time);
    end
  endtask

  // ---------------- reference model: frames as dibit runs, FIFO as a queue
  logic [9:0]  q[$];
  logic [1:0]  pay[$];
  bit          m_ovf, m_armed, in_run, dead, hunting, pv;
  logic [1:0]  pd;
  int          pre, sz;
  bit          m_pop, m_stat, m_push, m_oset;
  logic [9:0]  pushv;
  logic [31:0] exp_do = '0;
  logic        exp_irq = 1'b0;

  function automatic int neof();
    int n = 0;
    foreach (q[i]) if (q[i][8]) n++;
    return n;
  endfunction

  function automatic logic [7:0] byte_at(input int j);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) b[2*i +: 2] = pay[4*j + i];
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); pay.delete();
      m_ovf = 0; m_armed = 0; in_run = 0; dead = 0; hunting = 0; pv = 0; pd = 0;
      exp_do = '0; exp_irq = 1'b0;
    end else begin
      sz     = q.size();
      m_stat = bus.phy_re && bus.opb_addr[2];
      m_pop  = bus.phy_re && !bus.opb_addr[2] && sz > 0;
      if (bus.phy_re)
        exp_do = bus.opb_addr[2] ? {12'b0, m_ovf, sz == 64, sz == 0, 9'(neof()), 8'(sz)}
                                 : (sz > 0 ? {1'b1, 21'b0, q[0]} : 32'h0);
      m_push = 0;
      pushv  = '0;
      if (pv) begin
        if (!in_run) begin
          in_run = 1; dead = !m_armed; pre = 0; hunting = 1; pay.delete();
        end
        if (!dead) begin
          if (hunting) begin
            if (pd == 2'b01)                  pre++;
            else if (pd == 2'b11 && pre >= 8) hunting = 0;
            else                              dead = 1;
          end else begin
            pay.push_back(pd);
            if (pay.size() % 4 == 0 && pay.size() >= 8) begin
              m_push = 1;
              pushv  = {2'b00, byte_at(pay.size() / 4 - 2)};
            end
          end
        end
      end else if (in_run) begin
        in_run = 0;
        if (!dead && !hunting && pay.size() >= 4) begin
          m_push = 1;
          pushv  = {pay.size() % 4 != 0, 1'b1, byte_at(pay.size() / 4 - 1)};
        end
      end
      m_oset = m_push && sz == 64 && !m_pop;
      if (m_oset) begin m_push = 0; dead = 1; end
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(pushv);
      if (m_oset)      m_ovf = 1;
      else if (m_stat) m_ovf = 0;
      if (!bus.phy_rmii_rx_dv) m_armed = 1;
      pv = bus.phy_rmii_rx_dv;
      pd = {bus.phy_rmii_rx_data1, bus.phy_rmii_rx_data0};
      exp_irq = (neof() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("opb_do", bus.opb_do, exp_do);
      check("rx_irq", {31'b0, bus.rx_irq}, {31'b0, exp_irq});
    end
  end

  // ---------------- stimulus
  task automatic step(input logic dv, input logic [1:0] d, input logic re, input logic a2);
    @(negedge clk);
    bus.phy_rmii_rx_dv = dv;
    {bus.phy_rmii_rx_data1, bus.phy_rmii_rx_data0} = d;
    bus.phy_re   = re;
    bus.opb_addr = ($urandom & 32'hFFFF_FFFB) | {29'b0, a2, 2'b0};
  endtask

  task automatic dib(input logic dv, input logic [1:0] d);
    logic re, a2;
    re = 1'b0; a2 = 1'b0;
    if (rd_mode == 1) re = 1'b1;
    else if (rd_mode == 2) begin
      re = ($urandom % 3 == 0);
      a2 = ($urandom % 4 == 0);
    end
    step(dv, d, re, a2);
  endtask

  task automatic send_frame(input int pre_n, input int nb, input int extra);
    logic [7:0] b;
    for (int i = 0; i < pre_n; i++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
    for (int k = 0; k < nb; k++) begin
      b = fb[k];
      for (int i = 0; i < 4; i++) dib(1'b1, b[2*i +: 2]);
    end
    for (int i = 0; i < extra; i++) dib(1'b1, 2'($urandom));
    dib(1'b0, 2'b00);
  endtask

  task automatic rd(input logic a2, output logic [31:0] v);
    step(1'b0, 2'b00, 1'b1, a2);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    v = bus.opb_do;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) dib(1'b0, 2'b00);
  endtask

  initial begin
    bus.phy_rmii_rx_dv = 0; bus.phy_rmii_rx_data1 = 0; bus.phy_rmii_rx_data0 = 0;
    bus.phy_re = 0; bus.opb_addr = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("reset_do", bus.opb_do, 32'h0);
    check("reset_irq", {31'b0, bus.rx_irq}, 32'h0);
    idle(2);
    rd(1'b1, got); check("reset_stat", got, 32'h0002_0000);

    // basic two-byte frame
    fb[0] = 8'hA5; fb[1] = 8'h3C;
    send_frame(8, 2, 0); idle(2);
    check("t1_irq_before", {31'b0, bus.rx_irq}, 32'h1);
    rd(1'b0, got); check("t1_rd0", got, 32'h8000_00A5);
    check("t1_irq_mid", {31'b0, bus.rx_irq}, 32'h1);
    rd(1'b0, got); check("t1_rd1", got, 32'h8000_013C);
    check("t1_irq_after", {31'b0, bus.rx_irq}, 32'h0);
    rd(1'b0, got); check("t1_rd2", got, 32'h0);

    // short preamble is dropped
    send_frame(4, 2, 0); idle(2);
    rd(1'b1, got); check("t2_stat", got, 32'h0002_0000);

    // odd trailing dibit marks alignment error
    fb[0] = 8'h11; fb[1] = 8'h22;
    send_frame(8, 2, 1); idle(2);
    rd(1'b0, got); check("t3_rd0", got, 32'h8000_0011);
    rd(1'b0, got); check("t3_rd1", got, 32'h8000_0322);

    // overflow on a long frame
    for (int k = 0; k < 70; k++) fb[k] = 8'($urandom);
    send_frame(8, 70, 0); idle(2);
    rd(1'b1, got); check("t4_stat0", got, 32'h000C_0040);
    rd(1'b1, got); check("t4_stat1", got, 32'h0004_0040);
    rd_mode = 1; idle(70); rd_mode = 0;
    rd(1'b1, got); check("t4_drained", got, 32'h0002_0000);

    // back-to-back frames with a pop every cycle
    rd_mode = 1;
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
      send_frame(8, 4, 0);
    end
    idle(8); rd_mode = 0;
    rd(1'b1, got); check("t5_stat", got, 32'h0002_0000);

    // reset mid-frame with DV held high
    fb[0] = 8'h55;
    for (int i = 0; i < 8; i++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
    for (int i = 0; i < 6; i++) dib(1'b1, 2'($urandom));
    rst = 1;
    dib(1'b1, 2'b01); dib(1'b1, 2'b01);
    rst = 0;
    step(1'b1, 2'b10, 1'b1, 1'b1);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    check("t6_stat_rst", bus.opb_do, 32'h0002_0000);
    for (int i = 0; i < 8; i++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) dib(1'b1, 2'($urandom));
    idle(3);
    rd(1'b1, got); check("t6_stat_nopush", got, 32'h0002_0000);
    fb[0] = 8'h99;
    send_frame(8, 1, 0); idle(2);
    rd(1'b0, got); check("t6_new_frame", got, 32'h8000_0199);

    // randomized frames with random reads
    rd_mode = 2;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      send_frame($urandom_range(5, 11), $urandom_range(1, 8),
                 ($urandom % 4 == 0) ? $urandom_range(1, 3) : 0);
      idle($urandom_range(1, 3));
    end
    rd_mode = 1; idle(80); rd_mode = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
